// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the slice-serial adder scheduler.
package adder_sched_pkg;
   localparam int SLICE_W      = 3;
   localparam int N_SLICES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: a lone requester wins outright, a tie
// goes to whichever requester was not granted last.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       enable,
   output logic [1:0] grant
);
   // One-hot grant, all zero when not enabled.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
         else                grant = valid;
      end
   end
endmodule

// File: rtl/adder_scheduler.sv
// Time-multiplexes one external 3-bit adder across W-bit additions for two
// requesters: one slice per cycle, LSB slice first, carry rippled through a
// register between cycles.
module adder_scheduler
   import adder_sched_pkg::*;
#(
   parameter int N_SLICES = N_SLICES_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req0_valid,
   input  logic                        req1_valid,
   output logic                        req0_ready,
   output logic                        req1_ready,
   input  logic [SLICE_W*N_SLICES-1:0] req0_a,
   input  logic [SLICE_W*N_SLICES-1:0] req0_b,
   input  logic [SLICE_W*N_SLICES-1:0] req1_a,
   input  logic [SLICE_W*N_SLICES-1:0] req1_b,
   input  logic                        req0_cin,
   input  logic                        req1_cin,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [SLICE_W*N_SLICES-1:0] rsp_sum,
   output logic                        rsp_cout,
   output logic                        rsp_id,
   output logic [SLICE_W-1:0]          add_a,
   output logic [SLICE_W-1:0]          add_b,
   output logic                        add_cin,
   input  logic [SLICE_W-1:0]          add_sum,
   input  logic                        add_cout,
   output logic                        busy
);
   localparam int W  = SLICE_W * N_SLICES;
   localparam int KW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_SLICES - 1);

   state_t          state;
   logic [KW-1:0]   k;
   logic [W-1:0]    a_q, b_q;
   logic            carry;
   logic            last;
   logic [1:0]      grant;

   rr_arbiter2 u_arb (
      .valid  ({req1_valid, req0_valid}),
      .last   (last),
      .enable (state == IDLE),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign rsp_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   // Present the current slice to the shared adder; quiet outside RUN.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_q[SLICE_W*int'(k) +: SLICE_W];
         add_b   = b_q[SLICE_W*int'(k) +: SLICE_W];
         add_cin = carry;
      end
   end

   // Accept / slice-step / respond FSM; the result lives in rsp_sum directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         k        <= '0;
         carry    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_id   <= 1'b0;
         last     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  a_q    <= grant[1] ? req1_a   : req0_a;
                  b_q    <= grant[1] ? req1_b   : req0_b;
                  carry  <= grant[1] ? req1_cin : req0_cin;
                  rsp_id <= grant[1];
                  k      <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               rsp_sum[SLICE_W*int'(k) +: SLICE_W] <= add_sum;
               carry <= add_cout;
               if (k == K_LAST) begin
                  k        <= '0;
                  rsp_cout <= add_cout;
                  state    <= DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  last  <= rsp_id;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler with a behavioural 3-bit adder attached.
// Expected results are queued at accept time and compared at response time.
module tb_adder_scheduler;
   localparam int W = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic          req0_cin, req1_cin;
   logic          rsp_valid, rsp_ready;
   logic [W-1:0]  rsp_sum;
   logic          rsp_cout, rsp_id;
   logic [2:0]    add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic          busy;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

   adder_scheduler #(.N_SLICES(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_cin(req0_cin), .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .busy(busy)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         id;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cycle = 0;
   int   acc_cnt = 0;
   logic last_acc_id = 1'b0;
   logic prev_valid = 1'b0;
   bit   rand_rdy = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   task automatic push(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
      exp_t e;
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum = s[W-1:0];
      e.cout = s[W];
      e.id = id;
      e.acc = cycle;
      q.push_back(e);
      acc_cnt++;
      last_acc_id = id;
   endtask

   // Observe one cycle (inputs already driven at the falling edge), then
   // advance to the next falling edge.
   task automatic cyc();
      exp_t e;
      #1;
      if (rst) begin
         q.delete();
         prev_valid = 1'b0;
      end else begin
         if (req0_valid || req1_valid) chk("one_ready", 32'(req0_ready & req1_ready), 0);
         if (!busy || rsp_valid) chk("add_quiet", 32'({add_a, add_b, add_cin}), 0);
         if (req0_valid && req0_ready) push(1'b0, req0_a, req0_b, req0_cin);
         if (req1_valid && req1_ready) push(1'b1, req1_a, req1_b, req1_cin);
         if (rsp_valid && !prev_valid) begin
            // Accept sampled before edge c; DONE first seen before edge c+5,
            // i.e. four edges after the accepting edge.
            if (q.size() == 0) chk("spurious_rsp", 1, 0);
            else chk("latency", 32'(cycle - q[0].acc), 5);
         end
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("spurious_hs", 1, 0);
            else begin
               e = q.pop_front();
               chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
               chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
            end
         end
         prev_valid = rsp_valid;
      end
      @(negedge clk);
      cycle++;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
      int n0 = acc_cnt;
      int t = 0;
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
      while (acc_cnt == n0 && t < 60) begin cyc(); t++; end
      if (acc_cnt == n0) chk("send_timeout", 0, 1);
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 200) begin cyc(); t++; end
      chk("drain", 32'(q.size()), 0);
   endtask

   task automatic do_reset();
      rst = 1;
      cyc();
      cyc();
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] snap;
      logic [W-1:0] a3, b3;
      int ids[4];
      int n0, t;

      rst = 1; rsp_ready = 0;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_cin = 0; req1_cin = 0;
      @(negedge clk);
      do_reset();

      // Reset state
      #1;
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sum", 32'(rsp_sum), 0);
      chk("rst_cout", 32'(rsp_cout), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_add", 32'({add_a, add_b, add_cin}), 0);
      chk("rst_ready", 32'({req0_ready, req1_ready}), 0);

      // Full-width carry out: 0xFFF + 0x001
      rsp_ready = 1;
      send(0, 12'hFFF, 12'h001, 0);
      drain();

      // req1 with carry-in; watch the slices fed to the adder
      a3 = 12'h123; b3 = 12'h456;
      send(1, a3, b3, 1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("run_add_a", 32'(add_a), 32'((a3 >> (3 * i)) & 12'h7));
         chk("run_add_b", 32'(add_b), 32'((b3 >> (3 * i)) & 12'h7));
         if (i == 0) chk("run_cin0", 32'(add_cin), 1);
         cyc();
      end
      drain();

      // Both requesting after reset: alternation starting with req0; operands
      // scrambled every cycle so only accept-time values may count.
      do_reset();
      req0_valid = 1; req1_valid = 1;
      n0 = acc_cnt; t = 0;
      while (acc_cnt < n0 + 4 && t < 200) begin
         req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
         req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
         cyc();
         if (acc_cnt > n0 && acc_cnt <= n0 + 4) ids[acc_cnt - n0 - 1] = int'(last_acc_id);
         t++;
      end
      req0_valid = 0; req1_valid = 0;
      chk("rr_count", 32'(acc_cnt - n0), 4);
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(ids[i]), 32'(i % 2));
      drain();

      // Consumer stall in DONE for 5 cycles; accepted on the 6th
      rsp_ready = 0;
      send(0, 12'hABC, 12'h123, 1);
      t = 0;
      while (!rsp_valid && t < 20) begin cyc(); t++; end
      chk("stall_reach", 32'(rsp_valid), 1);
      snap = rsp_sum;
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_valid", 32'(rsp_valid), 1);
         chk("stall_sum", 32'(rsp_sum), 32'(snap));
         chk("stall_ready", 32'({req0_ready, req1_ready}), 0);
         chk("stall_busy", 32'(busy), 1);
         cyc();
      end
      req0_valid = 0; req1_valid = 0;
      rsp_ready = 1;
      cyc();
      #1;
      chk("stall_done", 32'(busy), 0);
      chk("stall_q", 32'(q.size()), 0);

      // Abort with reset while slice k=2 is on the adder
      send(0, 12'h555, 12'h2AA, 0);
      cyc();
      cyc();
      rst = 1;
      cyc();
      rst = 0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(rsp_valid), 0);
      chk("abort_add", 32'({add_a, add_b, add_cin}), 0);
      for (int i = 0; i < 10; i++) cyc();
      send(0, 12'h7FF, 12'h001, 0);
      drain();

      // Random traffic with a random consumer
      rand_rdy = 1;
      for (int i = 0; i < 8; i++)
         send(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      drain();
      rand_rdy = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
